// File: rtl/apb_pwm_cfg_master_pkg.sv
// Shared types and register map for the APB PWM configuration master.
package apb_pwm_pkg;

    localparam logic [31:0] PWM_PERIOD_OFS = 32'd0;
    localparam logic [31:0] PWM_PULSE_OFS  = 32'd4;
    localparam logic [31:0] PWM_SIZE_OFS   = 32'd8;
    localparam logic [31:0] PWM_ENABLE_OFS = 32'd12;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SLVERR   = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_MISMATCH = 2'd3
    } err_code_t;

    typedef enum logic {WR, RD} pass_t;

    // Byte offset of the PWM register selected by a 2-bit register index.
    function automatic logic [31:0] reg_ofs(input logic [1:0] idx);
        logic [31:0] ofs;
        case (idx)
            2'd0:    ofs = PWM_PERIOD_OFS;
            2'd1:    ofs = PWM_PULSE_OFS;
            2'd2:    ofs = PWM_SIZE_OFS;
            default: ofs = PWM_ENABLE_OFS;
        endcase
        return ofs;
    endfunction

endpackage

// File: rtl/apb_pwm_cfg_master_if.sv
// APB bus between the configuration master and the PWM slave.
interface apb_pwm_cfg_master_if;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLAVEERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLAVEERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLAVEERR
    );
endinterface

// File: rtl/apb_pwm_cfg_master_xfer.sv
// Single APB transfer engine: SETUP/ACCESS phases plus the PREADY wait timeout.
// A start request arriving in the completing ACCESS cycle chains straight into
// the next SETUP so PSEL stays high across back-to-back transfers.
module apb_pwm_xfer
    import apb_pwm_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic        complete,
    output logic        slverr,
    output logic        timeout,
    output logic [31:0] rdata,
    apb_pwm_cfg_master_if.master apb
);

    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

    state_t      phase, phase_nxt;
    logic [4:0]  wait_cnt;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        pwrite_q;

    assign complete = (phase == ACCESS) && apb.PREADY;
    assign timeout  = (phase == ACCESS) && !apb.PREADY && (wait_cnt == WAIT_LAST);
    assign slverr   = apb.PSLAVEERR;
    assign rdata    = apb.PRDATA;

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= IDLE;
        else        phase <= phase_nxt;
    end

    // Phase sequencing; DONE is never used by the transfer engine.
    always_comb begin
        phase_nxt = phase;
        case (phase)
            IDLE:    if (start) phase_nxt = SETUP;
            SETUP:   phase_nxt = ACCESS;
            ACCESS: begin
                if (apb.PREADY)   phase_nxt = start ? SETUP : IDLE;
                else if (timeout) phase_nxt = IDLE;
            end
            default: phase_nxt = IDLE;
        endcase
    end

    // Saturating wait counter, cleared in every SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                           wait_cnt <= '0;
        else if (phase == SETUP)                              wait_cnt <= '0;
        else if (phase == ACCESS && !apb.PREADY && wait_cnt != 5'd31) wait_cnt <= wait_cnt + 5'd1;
    end

    // Address/direction/data captured at start and held through ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else if (start) begin
            paddr_q  <= addr;
            pwdata_q <= wdata;
            pwrite_q <= write;
        end
    end

    assign apb.PSEL    = (phase == SETUP) || (phase == ACCESS);
    assign apb.PENABLE = (phase == ACCESS);
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PWRITE  = pwrite_q;

endmodule

// File: rtl/apb_pwm_cfg_master.sv
// Programs the four PWM registers from one command, with optional readback check.
//
//  state  | meaning
//  IDLE   | cfg_ready high, waiting for cfg_valid
//  SETUP  | APB setup phase for register idx of the current pass
//  ACCESS | APB access phase, waiting for PREADY or timeout
//  DONE   | one-cycle done pulse with err/err_code
module apb_pwm_cfg_master
    import apb_pwm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          TIMEOUT   = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_period,
    input  logic [31:0] cfg_pulse,
    input  logic [31:0] cfg_size,
    input  logic [31:0] cfg_enable,
    input  logic        cfg_verify,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    apb_pwm_cfg_master_if.master apb
);

    state_t          state, state_nxt;
    logic [1:0]      idx, idx_nxt;
    pass_t           pass, pass_nxt;
    err_code_t       code, code_nxt;
    logic [3:0][31:0] cmd;
    logic [3:0][31:0] cmd_src;
    logic            verify;

    logic            start;
    logic [31:0]     x_addr;
    logic            x_write;
    logic [31:0]     x_wdata;
    logic            x_complete;
    logic            x_slverr;
    logic            x_timeout;
    logic [31:0]     x_rdata;

    // Command registers, latched on the accept edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cmd    <= '0;
            verify <= 1'b0;
        end else if (state == IDLE && cfg_valid) begin
            cmd    <= {cfg_enable, cfg_size, cfg_pulse, cfg_period};
            verify <= cfg_verify;
        end
    end

    // Sequencer state, register index, pass and result code.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            idx   <= 2'd0;
            pass  <= WR;
            code  <= ERR_NONE;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            pass  <= pass_nxt;
            code  <= code_nxt;
        end
    end

    // Next-state logic; a transfer is launched on accept and on each clean completion.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pass_nxt  = pass;
        code_nxt  = code;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    state_nxt = SETUP;
                    idx_nxt   = 2'd0;
                    pass_nxt  = WR;
                    code_nxt  = ERR_NONE;
                    start     = 1'b1;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (x_timeout) begin
                    code_nxt  = ERR_TIMEOUT;
                    state_nxt = DONE;
                end else if (x_complete) begin
                    if (x_slverr) begin
                        code_nxt  = ERR_SLVERR;
                        state_nxt = DONE;
                    end else if (pass == RD && x_rdata != cmd[idx]) begin
                        code_nxt  = ERR_MISMATCH;
                        state_nxt = DONE;
                    end else if (idx == 2'd3 && (pass == RD || !verify)) begin
                        state_nxt = DONE;
                    end else begin
                        start     = 1'b1;
                        state_nxt = SETUP;
                        if (idx == 2'd3) begin
                            idx_nxt  = 2'd0;
                            pass_nxt = RD;
                        end else begin
                            idx_nxt = idx + 2'd1;
                        end
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // On accept the command is not latched yet, so write data comes straight from the inputs.
    assign cmd_src = (state == IDLE) ? {cfg_enable, cfg_size, cfg_pulse, cfg_period} : cmd;
    assign x_addr  = BASE_ADDR + reg_ofs(idx_nxt);
    assign x_write = (pass_nxt == WR);
    assign x_wdata = x_write ? cmd_src[idx_nxt] : 32'd0;

    apb_pwm_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .start    (start),
        .addr     (x_addr),
        .write    (x_write),
        .wdata    (x_wdata),
        .complete (x_complete),
        .slverr   (x_slverr),
        .timeout  (x_timeout),
        .rdata    (x_rdata),
        .apb      (apb)
    );

    assign cfg_ready = (state == IDLE);
    assign done      = (state == DONE);
    assign err       = done && (code != ERR_NONE);
    assign err_code  = done ? code : ERR_NONE;

endmodule

// File: tb/tb_apb_pwm_cfg_master.sv
// Directed bench for the APB PWM configuration master with a configurable slave stub.
module tb_apb_pwm_cfg_master;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_period = '0;
    logic [31:0] cfg_pulse = '0;
    logic [31:0] cfg_size = '0;
    logic [31:0] cfg_enable = '0;
    logic        cfg_verify = 1'b0;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    apb_pwm_cfg_master_if apb_bus();

    apb_pwm_cfg_master #(
        .BASE_ADDR (32'h0),
        .TIMEOUT   (16)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_pulse  (cfg_pulse),
        .cfg_size   (cfg_size),
        .cfg_enable (cfg_enable),
        .cfg_verify (cfg_verify),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .apb        (apb_bus)
    );

    always #5 PCLK = ~PCLK;

    // Slave stub configuration.
    logic        wait_en = 1'b0;
    logic [31:0] wait_addr = '0;
    logic [3:0]  wait_n = '0;
    logic        serr_en = 1'b0;
    logic [31:0] serr_addr = '0;
    logic        stuck_en = 1'b0;
    logic [31:0] stuck_addr = '0;
    logic        bad_en = 1'b0;
    logic [31:0] bad_addr = '0;
    logic [31:0] bad_val = '0;
    logic [31:0] mon_addr = '0;
    logic [31:0] mon_data = '0;

    logic [31:0] mem [4];
    logic [3:0]  wcnt;

    // Monitor state, written only by the monitor process.
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_write[$];
    int          done_cnt = 0;
    int          pen_hit = 0;
    int          sel12 = 0;

    int n_chk = 0;
    int n_pass = 0;

    // Slave response: optional wait states, stuck PREADY, error and corrupted readback.
    always_comb begin
        apb_bus.PREADY = 1'b1;
        if (stuck_en && apb_bus.PADDR == stuck_addr)
            apb_bus.PREADY = 1'b0;
        else if (wait_en && apb_bus.PADDR == wait_addr && wcnt < wait_n)
            apb_bus.PREADY = 1'b0;
        apb_bus.PSLAVEERR = serr_en && (apb_bus.PADDR == serr_addr);
        apb_bus.PRDATA = (bad_en && apb_bus.PADDR == bad_addr) ? bad_val : mem[apb_bus.PADDR[3:2]];
    end

    // Slave register file and wait-state counter.
    always @(posedge PCLK) begin
        if (apb_bus.PSEL && apb_bus.PENABLE && !apb_bus.PREADY) wcnt <= wcnt + 4'd1;
        else                                                   wcnt <= 4'd0;
        if (apb_bus.PSEL && apb_bus.PENABLE && apb_bus.PREADY && apb_bus.PWRITE && !apb_bus.PSLAVEERR)
            mem[apb_bus.PADDR[3:2]] <= apb_bus.PWDATA;
    end

    // Bus monitor.
    always @(posedge PCLK) begin
        if (apb_bus.PSEL && apb_bus.PENABLE && apb_bus.PREADY) begin
            log_addr.push_back(apb_bus.PADDR);
            log_write.push_back(apb_bus.PWRITE);
            log_data.push_back(apb_bus.PWRITE ? apb_bus.PWDATA : apb_bus.PRDATA);
        end
        if (apb_bus.PSEL && apb_bus.PENABLE && apb_bus.PADDR == mon_addr && apb_bus.PWDATA == mon_data)
            pen_hit <= pen_hit + 1;
        if (apb_bus.PSEL && apb_bus.PADDR == 32'd12)
            sel12 <= sel12 + 1;
        if (done)
            done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one command; returns the cycle (1 = first cycle after accept) in which done was seen.
    task automatic run_cmd(input logic [31:0] p, input logic [31:0] pu, input logic [31:0] s,
                           input logic [31:0] e, input logic v,
                           output int cyc, output logic err_o, output logic [1:0] code_o);
        int guard;
        @(negedge PCLK);
        cfg_period = p;
        cfg_pulse  = pu;
        cfg_size   = s;
        cfg_enable = e;
        cfg_verify = v;
        cfg_valid  = 1'b1;
        guard = 0;
        while (!cfg_ready && guard < 50) begin
            @(negedge PCLK);
            guard++;
        end
        @(posedge PCLK);
        #1;
        cfg_valid  = 1'b0;
        cfg_period = '1;
        cfg_pulse  = '1;
        cfg_size   = '1;
        cfg_enable = '1;
        cfg_verify = ~v;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge PCLK);
            #1;
            cyc++;
        end
        if (!done) cyc = -1;
        err_o  = err;
        code_o = err_code;
        @(posedge PCLK);
        #1;
    endtask

    logic [31:0] exp_d [4];
    int          cyc;
    int          base;
    int          snap;
    int          guard;
    logic        e_o;
    logic [1:0]  c_o;

    initial begin
        exp_d[0] = 32'd8;
        exp_d[1] = 32'd2;
        exp_d[2] = 32'd10;
        exp_d[3] = 32'd1;
        for (int i = 0; i < 4; i++) mem[i] = '0;

        // Reset values
        repeat (3) @(posedge PCLK);
        #1;
        check_val("rst_cfg_ready", cfg_ready, 1);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_err_code", err_code, 0);
        check_val("rst_psel", apb_bus.PSEL, 0);
        check_val("rst_penable", apb_bus.PENABLE, 0);
        check_val("rst_pwrite", apb_bus.PWRITE, 0);
        check_val("rst_paddr", apb_bus.PADDR, 0);
        check_val("rst_pwdata", apb_bus.PWDATA, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // 1: write-only, zero wait states
        base = log_addr.size();
        run_cmd(8, 2, 10, 1, 1'b0, cyc, e_o, c_o);
        check_val("t1_cycle", 32'(cyc), 9);
        check_val("t1_err", e_o, 0);
        check_val("t1_code", c_o, 0);
        check_val("t1_nxfer", 32'(log_addr.size() - base), 4);
        if (log_addr.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                check_val($sformatf("t1_addr%0d", i), log_addr[base+i], 32'(4 * i));
                check_val($sformatf("t1_wdata%0d", i), log_data[base+i], exp_d[i]);
                check_val($sformatf("t1_write%0d", i), log_write[base+i], 1);
            end
        end

        // 2: write then verify against the register-file stub
        base = log_addr.size();
        run_cmd(8, 2, 10, 1, 1'b1, cyc, e_o, c_o);
        check_val("t2_cycle", 32'(cyc), 17);
        check_val("t2_err", e_o, 0);
        check_val("t2_nxfer", 32'(log_addr.size() - base), 8);
        if (log_addr.size() >= base + 8) begin
            for (int i = 0; i < 4; i++) begin
                check_val($sformatf("t2_raddr%0d", i), log_addr[base+4+i], 32'(4 * i));
                check_val($sformatf("t2_rdata%0d", i), log_data[base+4+i], exp_d[i]);
                check_val($sformatf("t2_rdir%0d", i), log_write[base+4+i], 0);
            end
        end

        // 3: three wait states on the PULSE write
        wait_en = 1'b1; wait_addr = 32'd4; wait_n = 4'd3;
        mon_addr = 32'd4; mon_data = 32'd2;
        snap = pen_hit;
        run_cmd(8, 2, 10, 1, 1'b0, cyc, e_o, c_o);
        check_val("t3_cycle", 32'(cyc), 12);
        check_val("t3_err", e_o, 0);
        check_val("t3_penable_hold", 32'(pen_hit - snap), 4);
        wait_en = 1'b0;

        // 4: slave error on the SIZE write
        serr_en = 1'b1; serr_addr = 32'd8;
        snap = sel12;
        base = log_addr.size();
        run_cmd(8, 2, 10, 1, 1'b0, cyc, e_o, c_o);
        check_val("t4_cycle", 32'(cyc), 7);
        check_val("t4_err", e_o, 1);
        check_val("t4_code", c_o, 1);
        check_val("t4_no_enable_xfer", 32'(sel12 - snap), 0);
        check_val("t4_nxfer", 32'(log_addr.size() - base), 3);
        serr_en = 1'b0;

        // 5: PREADY stuck low on the PERIOD write
        stuck_en = 1'b1; stuck_addr = 32'd0;
        mon_addr = 32'd0; mon_data = 32'd8;
        snap = pen_hit;
        base = log_addr.size();
        run_cmd(8, 2, 10, 1, 1'b0, cyc, e_o, c_o);
        check_val("t5_cycle", 32'(cyc), 18);
        check_val("t5_err", e_o, 1);
        check_val("t5_code", c_o, 2);
        check_val("t5_access_cycles", 32'(pen_hit - snap), 16);
        check_val("t5_nxfer", 32'(log_addr.size() - base), 0);
        check_val("t5_psel_after", apb_bus.PSEL, 0);
        stuck_en = 1'b0;

        // 5b: corrupted PULSE readback
        bad_en = 1'b1; bad_addr = 32'd4; bad_val = 32'd3;
        run_cmd(8, 2, 10, 1, 1'b1, cyc, e_o, c_o);
        check_val("t5b_cycle", 32'(cyc), 13);
        check_val("t5b_err", e_o, 1);
        check_val("t5b_code", c_o, 3);
        bad_en = 1'b0;

        // 6: reset during the ACCESS of idx 2
        @(negedge PCLK);
        cfg_period = 8; cfg_pulse = 2; cfg_size = 10; cfg_enable = 1;
        cfg_verify = 1'b0; cfg_valid = 1'b1;
        @(posedge PCLK);
        #1;
        cfg_valid = 1'b0;
        guard = 0;
        while (!(apb_bus.PSEL && apb_bus.PENABLE && apb_bus.PADDR == 32'd8) && guard < 20) begin
            @(posedge PCLK);
            #1;
            guard++;
        end
        check_val("t6_reach_idx2", 32'(apb_bus.PENABLE && apb_bus.PADDR == 32'd8), 1);
        snap = done_cnt;
        #2;
        PRESETn = 1'b0;
        #1;
        check_val("t6_psel_drop", apb_bus.PSEL, 0);
        check_val("t6_penable_drop", apb_bus.PENABLE, 0);
        repeat (3) @(posedge PCLK);
        #1;
        check_val("t6_no_done", 32'(done_cnt - snap), 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        check_val("t6_cfg_ready", cfg_ready, 1);
        base = log_addr.size();
        run_cmd(8, 2, 10, 1, 1'b0, cyc, e_o, c_o);
        check_val("t6_fresh_cycle", 32'(cyc), 9);
        check_val("t6_fresh_err", e_o, 0);
        check_val("t6_fresh_nxfer", 32'(log_addr.size() - base), 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
